// File: rtl/simple_bus.sv
// simple_bus: N-host to M-device interconnect, one outstanding transaction.
// BUS_RR_ARB_EN: round-robin arbitration instead of fixed lowest-index priority.
module simple_bus #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NrHosts-1:0]                     host_req_i,
  output logic [NrHosts-1:0]                     host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                     host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                     host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                     host_err_o,
  output logic [NrDevices-1:0]                   device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o,
  output logic [NrDevices-1:0]                   device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]  device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o,
  input  logic [NrDevices-1:0]                   device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i,
  input  logic [NrDevices-1:0]                   device_err_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask
);

  localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  typedef struct packed {
    logic                vld;
    logic                unmapped;
    logic [HostIdxW-1:0] host;
    logic [DevIdxW-1:0]  dev;
  } rsp_sel_t;

  logic                    w_host_found;
  logic [HostIdxW-1:0]     w_host_sel;
  logic                    w_grant;
  logic                    w_dev_hit;
  logic [DevIdxW-1:0]      w_dev_sel;
  logic [AddressWidth-1:0] w_addr;
  rsp_sel_t                r_rsp;

  assign w_host_found = |host_req_i;
  assign w_grant      = w_host_found & ~rst_i;

`ifdef BUS_RR_ARB_EN
  localparam logic [HostIdxW:0]   HostCnt  = (HostIdxW+1)'(NrHosts);
  localparam logic [HostIdxW-1:0] HostLast = HostIdxW'(NrHosts-1);

  logic [HostIdxW-1:0]    r_rr_ptr;
  logic [2*NrHosts-1:0]   w_req_dbl;
  logic [HostIdxW-1:0]    w_rot_off;
  logic [HostIdxW:0]      w_rot_sum;

  // Rotate requests so the pointer sits at bit 0, then find the first one.
  always_comb begin
    w_req_dbl = {host_req_i, host_req_i} >> r_rr_ptr;
    w_rot_off = '0;
    for (int i = NrHosts-1; i >= 0; i--) begin
      if (w_req_dbl[i]) w_rot_off = HostIdxW'(i);
    end
    w_rot_sum = {1'b0, r_rr_ptr} + {1'b0, w_rot_off};
    if (w_rot_sum >= HostCnt) w_rot_sum = w_rot_sum - HostCnt;
    w_host_sel = w_rot_sum[HostIdxW-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_host_sel == HostLast) ? '0 : w_host_sel + 1'b1;
    end
  end
`else
  always_comb begin
    w_host_sel = '0;
    for (int i = NrHosts-1; i >= 0; i--) begin
      if (host_req_i[i]) w_host_sel = HostIdxW'(i);
    end
  end
`endif

  assign w_addr = host_addr_i[w_host_sel];

  always_comb begin
    w_dev_hit = 1'b0;
    w_dev_sel = '0;
    for (int d = NrDevices-1; d >= 0; d--) begin
      if ((w_addr & cfg_device_addr_mask[d]) ==
          (cfg_device_addr_base[d] & cfg_device_addr_mask[d])) begin
        w_dev_hit = 1'b1;
        w_dev_sel = DevIdxW'(d);
      end
    end
  end

  always_comb begin
    host_gnt_o = '0;
    if (w_grant) host_gnt_o[w_host_sel] = 1'b1;
  end

  always_comb begin
    device_req_o = '0;
    for (int d = 0; d < NrDevices; d++) begin
      device_addr_o[d]  = w_addr;
      device_we_o[d]    = host_we_i[w_host_sel];
      device_be_o[d]    = host_be_i[w_host_sel];
      device_wdata_o[d] = host_wdata_i[w_host_sel];
    end
    if (w_grant && w_dev_hit) device_req_o[w_dev_sel] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp <= '0;
    end else begin
      r_rsp.vld      <= w_grant;
      r_rsp.unmapped <= ~w_dev_hit;
      r_rsp.host     <= w_host_sel;
      r_rsp.dev      <= w_dev_sel;
    end
  end

  // Only the registered host sees a response; everyone else reads zero.
  always_comb begin
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    if (r_rsp.vld) begin
      if (r_rsp.unmapped) begin
        host_rvalid_o[r_rsp.host] = 1'b1;
        host_err_o[r_rsp.host]    = 1'b1;
      end else begin
        host_rvalid_o[r_rsp.host] = device_rvalid_i[r_rsp.dev];
        host_rdata_o[r_rsp.host]  = device_rdata_i[r_rsp.dev];
        host_err_o[r_rsp.host]    = device_err_i[r_rsp.dev];
      end
    end
  end

endmodule

// File: tb/tb_simple_bus.sv
// tb_simple_bus: scoreboard bench for simple_bus, 2 hosts, 3 devices
// (RAM, SimCtrl, timer). Device model answers one cycle after request.
module tb_simple_bus;

  localparam int NH = 2;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic                   clk;
  logic                   rst;
  logic [NH-1:0]          host_req;
  logic [NH-1:0]          host_gnt;
  logic [NH-1:0][AW-1:0]  host_addr;
  logic [NH-1:0]          host_we;
  logic [NH-1:0][DW/8-1:0] host_be;
  logic [NH-1:0][DW-1:0]  host_wdata;
  logic [NH-1:0]          host_rvalid;
  logic [NH-1:0][DW-1:0]  host_rdata;
  logic [NH-1:0]          host_err;
  logic [ND-1:0]          device_req;
  logic [ND-1:0][AW-1:0]  device_addr;
  logic [ND-1:0]          device_we;
  logic [ND-1:0][DW/8-1:0] device_be;
  logic [ND-1:0][DW-1:0]  device_wdata;
  logic [ND-1:0]          device_rvalid;
  logic [ND-1:0][DW-1:0]  device_rdata;
  logic [ND-1:0]          device_err;
  logic [ND-1:0][AW-1:0]  cfg_base;
  logic [ND-1:0][AW-1:0]  cfg_mask;

  logic [31:0]   dev_val [ND];
  logic [ND-1:0] dev_errv;
  logic [ND-1:0] spur;

  exp_t sb[$];
  exp_t mon_e;
  int   checks;
  int   errors;
  int   rr_ptr;

  simple_bus #(
    .NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(host_gnt),
    .host_addr_i(host_addr), .host_we_i(host_we),
    .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
    .host_err_o(host_err),
    .device_req_o(device_req), .device_addr_o(device_addr),
    .device_we_o(device_we), .device_be_o(device_be),
    .device_wdata_o(device_wdata),
    .device_rvalid_i(device_rvalid), .device_rdata_i(device_rdata),
    .device_err_i(device_err),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      device_rvalid[d] <= device_req[d] | spur[d];
      device_rdata[d]  <= dev_val[d];
      device_err[d]    <= dev_errv[d];
    end
  end

  function automatic int exp_win(input logic [NH-1:0] req);
`ifdef BUS_RR_ARB_EN
    for (int i = 0; i < NH; i++) begin
      if (req[(rr_ptr + i) % NH]) return (rr_ptr + i) % NH;
    end
    return 0;
`else
    for (int i = 0; i < NH; i++) begin
      if (req[i]) return i;
    end
    return 0;
`endif
  endfunction

  task automatic idle();
    host_req = '0;
    host_we  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    host_req = 2'b01;
    host_addr[0] = 32'h0010_0004;
    @(negedge clk);
    #1;
    checks++;
    if (host_gnt !== 2'b00) begin
      errors++; $display("FAIL reset_gnt got %b want 00", host_gnt);
    end
    checks++;
    if (device_req !== 3'b000) begin
      errors++; $display("FAIL reset_dev_req got %b want 000", device_req);
    end
    checks++;
    if (host_rvalid !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid got %b want 00", host_rvalid);
    end
    checks++;
    if (host_err !== 2'b00) begin
      errors++; $display("FAIL reset_err got %b want 00", host_err);
    end
    checks++;
    if (host_rdata !== '0) begin
      errors++; $display("FAIL reset_rdata got %h want 0", host_rdata);
    end
    idle();
    rst = 1'b0;
    rr_ptr = 0;
  endtask

  task automatic test_read();
    @(negedge clk);
    host_req = 2'b01;
    host_addr[0] = 32'h0010_0004;
    host_be[0] = 4'hF;
    #1;
    checks++;
    if (host_gnt !== 2'b01) begin
      errors++; $display("FAIL read_gnt got %b want 01", host_gnt);
    end
    checks++;
    if (device_req !== 3'b001) begin
      errors++; $display("FAIL read_dev_req got %b want 001", device_req);
    end
    checks++;
    if (device_addr[0] !== 32'h0010_0004) begin
      errors++; $display("FAIL read_addr got %h want 00100004", device_addr[0]);
    end
    sb.push_back('{0, 32'hDEAD_BEEF, 1'b0});
    rr_ptr = 1;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL read_rsp_missing got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    host_req = 2'b01;
    host_addr[0] = 32'h0002_0008;
    host_we[0] = 1'b1;
    host_be[0] = 4'hF;
    host_wdata[0] = 32'h41;
    #1;
    checks++;
    if (device_req !== 3'b010) begin
      errors++; $display("FAIL write_dev_req got %b want 010", device_req);
    end
    checks++;
    if (device_addr[1] !== 32'h0002_0008 || device_we[1] !== 1'b1 ||
        device_be[1] !== 4'hF || device_wdata[1] !== 32'h41) begin
      errors++;
      $display("FAIL write_fwd got a=%h we=%b be=%h wd=%h want 00020008 1 f 00000041",
               device_addr[1], device_we[1], device_be[1], device_wdata[1]);
    end
    sb.push_back('{0, dev_val[1], 1'b0});
    rr_ptr = 1;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL write_rsp_missing got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_unmapped();
    @(negedge clk);
    host_req = 2'b01;
    host_addr[0] = 32'h0005_0000;
    #1;
    checks++;
    if (host_gnt !== 2'b01) begin
      errors++; $display("FAIL unmapped_gnt got %b want 01", host_gnt);
    end
    checks++;
    if (device_req !== 3'b000) begin
      errors++; $display("FAIL unmapped_dev_req got %b want 000", device_req);
    end
    sb.push_back('{0, 32'h0, 1'b1});
    rr_ptr = 1;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL unmapped_rsp_missing got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_dev_err();
    @(negedge clk);
    dev_errv[2] = 1'b1;
    host_req = 2'b10;
    host_addr[1] = 32'h0003_0010;
    #1;
    checks++;
    if (host_gnt !== 2'b10) begin
      errors++; $display("FAIL deverr_gnt got %b want 10", host_gnt);
    end
    checks++;
    if (device_req !== 3'b100) begin
      errors++; $display("FAIL deverr_dev_req got %b want 100", device_req);
    end
    sb.push_back('{1, dev_val[2], 1'b1});
    rr_ptr = 0;
    @(negedge clk);
    idle();
    dev_errv[2] = 1'b0;
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL deverr_rsp_missing got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int w;
    host_addr[0] = 32'h0010_0010;
    host_addr[1] = 32'h0003_0004;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      host_req = 2'b11;
      #1;
      w = exp_win(2'b11);
      checks++;
      if (host_gnt !== NH'(1 << w)) begin
        errors++; $display("FAIL arb_gnt cycle %0d got %b want host %0d", c, host_gnt, w);
      end
      checks++;
      if (device_req !== ((w == 0) ? 3'b001 : 3'b100)) begin
        errors++; $display("FAIL arb_dev_req cycle %0d got %b for host %0d", c, device_req, w);
      end
      sb.push_back('{w, dev_val[(w == 0) ? 0 : 2], 1'b0});
      rr_ptr = (w + 1) % NH;
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_rsp_missing got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    idle();
    spur = 3'b111;
    @(negedge clk);
    spur = 3'b000;
    #1;
    checks++;
    if (host_rvalid !== 2'b00) begin
      errors++; $display("FAIL spurious_rvalid got %b want 00", host_rvalid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    host_req = 2'b01;
    host_addr[0] = 32'h0010_0008;
    #1;
    checks++;
    if (host_gnt !== 2'b01) begin
      errors++; $display("FAIL rstmid_gnt got %b want 01", host_gnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    rr_ptr = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b0;
      #1;
      checks++;
      if (host_rvalid !== 2'b00) begin
        errors++; $display("FAIL rstmid_rvalid cycle %0d got %b want 00", c, host_rvalid);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rr_ptr = 0;
    rst = 1'b1;
    spur = '0;
    dev_errv = '0;
    dev_val[0] = 32'hDEAD_BEEF;
    dev_val[1] = 32'h0000_0001;
    dev_val[2] = 32'h1234_5678;
    host_req = '0;
    host_we = '0;
    host_addr = '0;
    host_be = '0;
    host_wdata = '0;
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'hF_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h3FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h3FF;

    fork
      forever begin
        @(negedge clk);
        for (int h = 0; h < NH; h++) begin
          checks++;
          if (host_rvalid[h] === 1'b1) begin
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL rsp_unexpected host %0d got rvalid=1 want 0", h);
            end else begin
              mon_e = sb.pop_front();
              if (mon_e.host != h || host_rdata[h] !== mon_e.rdata ||
                  host_err[h] !== mon_e.err) begin
                errors++;
                $display("FAIL rsp_data host %0d got rdata=%h err=%b want host %0d rdata=%h err=%b",
                         h, host_rdata[h], host_err[h], mon_e.host, mon_e.rdata, mon_e.err);
              end
            end
          end else if (host_rdata[h] !== '0 || host_err[h] !== 1'b0) begin
            errors++;
            $display("FAIL rsp_idle host %0d got rdata=%h err=%b want 0 0",
                     h, host_rdata[h], host_err[h]);
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
      end
    join_none

    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_dev_err();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL final_queue got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
